syn_sram_acc_arb: RTL and testbench

//  Two-port arbiter for the single shared SRAM access channel. Port 0 is the VGA line-buffer read

---
 rtl/syn_sram_acc_arb.sv | 238 +++++++++++++++++++++++
 tb/tb_syn_sram_acc_arb.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/syn_sram_acc_arb.sv
// ============================================================================
// syn_sram_acc_arb
// ----------------------------------------------------------------------------
// Arbiter between two requesters for the single shared SRAM access channel.
// Port 0 is the VGA line-buffer read stream. Port 1 is the GPU pixel
// read/write path. Only one requester is granted at a time, and VGA has
// priority. Read data comes back from the controller in issue order. A small
// tag FIFO records which requester issued each outstanding read, so that
// every return is steered to the requester that issued it.
//
// Optional build macro: SYN_SRAM_ARB_STARVE_GUARD_EN
//   Defined   : the GPU is promoted once it has waited P_STARVE_LIM cycles.
//   Undefined : strict VGA priority.
//
// Ports
//   clk_ir, rst_sync_l          clock and synchronous active-low reset
//   vga_req/addr                VGA read request (read-only port)
//   vga_ack                     VGA transfer accepted this cycle
//   vga_rd_valid/rdata          registered VGA read return
//   gpu_req/wr/addr/wdata       GPU request (wr=1 for write)
//   gpu_ack                     GPU transfer accepted this cycle
//   gpu_rd_valid/rdata          registered GPU read return
//   sram_req/wr/addr/wdata      request to the SRAM access controller
//   sram_ready                  controller accepts when sram_req & sram_ready
//   sram_rd_valid/rdata         read return from the controller, in issue order
// ============================================================================
module syn_sram_acc_arb #(
    parameter int P_ADDR_W     = 18,
    parameter int P_DATA_W     = 16,
    parameter int P_MAX_BURST  = 16,
    parameter int P_OUTST_MAX  = 4,
    parameter int P_STARVE_LIM = 64
) (
    input  logic                clk_ir,
    input  logic                rst_sync_l,
    input  logic                vga_req,
    input  logic [P_ADDR_W-1:0] vga_addr,
    output logic                vga_ack,
    output logic                vga_rd_valid,
    output logic [P_DATA_W-1:0] vga_rdata,
    input  logic                gpu_req,
    input  logic                gpu_wr,
    input  logic [P_ADDR_W-1:0] gpu_addr,
    input  logic [P_DATA_W-1:0] gpu_wdata,
    output logic                gpu_ack,
    output logic                gpu_rd_valid,
    output logic [P_DATA_W-1:0] gpu_rdata,
    output logic                sram_req,
    output logic                sram_wr,
    output logic [P_ADDR_W-1:0] sram_addr,
    output logic [P_DATA_W-1:0] sram_wdata,
    input  logic                sram_ready,
    input  logic                sram_rd_valid,
    input  logic [P_DATA_W-1:0] sram_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GNT_VGA = 2'd1,
        ST_GNT_GPU = 2'd2
    } state_t;

    localparam int CW = $clog2(P_MAX_BURST + 1);
    localparam int PW = (P_OUTST_MAX > 1) ? $clog2(P_OUTST_MAX) : 1;
    localparam int NW = $clog2(P_OUTST_MAX + 1);
    localparam logic [CW-1:0] BURST_LAST = CW'(P_MAX_BURST - 1);
    localparam logic [PW-1:0] PTR_LAST   = PW'(P_OUTST_MAX - 1);
    localparam logic [NW-1:0] FIFO_DEPTH = NW'(P_OUTST_MAX);

    state_t                state;
    logic [CW-1:0]         burst_cnt;

    logic [P_OUTST_MAX-1:0] tag_mem;     // 0 = VGA, 1 = GPU
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [NW-1:0]          fifo_cnt;
    logic                   proto_err;   // sticky: return arrived with nothing outstanding

    logic                   grant_vga;
    logic                   grant_gpu;
    logic                   sel_req;
    logic                   fifo_full;
    logic                   pop;
    logic                   push;
    logic                   stall;
    logic                   xfer;
    logic                   head_tag;
    logic                   starved;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Request path: the granted port drives the SRAM channel directly.
    // ------------------------------------------------------------------
    // NOTE: combinational blocks use blocking '='. Every output also gets a
    // default value first, so no path through the block infers a latch.
    always_comb begin
        grant_vga  = (state == ST_GNT_VGA);
        grant_gpu  = (state == ST_GNT_GPU);
        sel_req    = 1'b0;
        sram_wr    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (grant_vga) begin
            sel_req   = vga_req;
            sram_addr = vga_addr;
        end else if (grant_gpu) begin
            sel_req    = gpu_req;
            sram_wr    = gpu_wr;
            sram_addr  = gpu_addr;
            sram_wdata = gpu_wdata;
        end

        fifo_full = (fifo_cnt == FIFO_DEPTH);
        pop       = sram_rd_valid && (fifo_cnt != '0);
        // A read may be accepted into a full FIFO on the same cycle the
        // head is popped. Writes take no tag, so they never stall.
        stall     = !sram_wr && fifo_full && !pop;
        sram_req  = sel_req && !stall;
        xfer      = sram_req && sram_ready;
        vga_ack   = xfer && grant_vga;
        gpu_ack   = xfer && grant_gpu;
        push      = xfer && !sram_wr;
        head_tag  = tag_mem[rd_ptr];
    end

    // ------------------------------------------------------------------
    // Starvation guard
    // ------------------------------------------------------------------
`ifdef SYN_SRAM_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(P_STARVE_LIM + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(P_STARVE_LIM);

    logic [SW-1:0] wait_cnt;

    // The counter saturates at the limit. It stays there until the GPU is
    // finally served.
    always_ff @(posedge clk_ir) begin
        if (!rst_sync_l) begin
            wait_cnt <= '0;
        end else if (gpu_ack) begin
            wait_cnt <= '0;
        end else if (gpu_req && wait_cnt != STARVE_LIM) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign starved = (wait_cnt >= STARVE_LIM);
`else
    logic unused_starve_lim;
    assign unused_starve_lim = (P_STARVE_LIM != 0);
    assign starved           = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Grant FSM and burst counter
    // ------------------------------------------------------------------
    // NOTE: sequential state is updated only with non-blocking '<='.
    always_ff @(posedge clk_ir) begin
        if (!rst_sync_l) begin
            state     <= ST_IDLE;
            burst_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    burst_cnt <= '0;
                    if (gpu_req && starved) state <= ST_GNT_GPU;
                    else if (vga_req)       state <= ST_GNT_VGA;
                    else if (gpu_req)       state <= ST_GNT_GPU;
                end
                ST_GNT_VGA, ST_GNT_GPU: begin
                    if (!sel_req) begin
                        state     <= ST_IDLE;
                        burst_cnt <= '0;
                    end else if (xfer) begin
                        if (burst_cnt == BURST_LAST || (grant_vga && starved)) begin
                            state     <= ST_IDLE;
                            burst_cnt <= '0;
                        end else begin
                            burst_cnt <= burst_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    burst_cnt <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Tag FIFO control
    // ------------------------------------------------------------------
    always_ff @(posedge clk_ir) begin
        if (!rst_sync_l) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            proto_err <= 1'b0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
            else if (pop && !push) fifo_cnt <= fifo_cnt - 1'b1;
            if (sram_rd_valid && fifo_cnt == '0) proto_err <= 1'b1;
        end
    end

    // NOTE: tag storage has no reset. fifo_cnt guards every read, so a stale
    // entry is never observed.
    always_ff @(posedge clk_ir) begin
        if (push) tag_mem[wr_ptr] <= grant_gpu;
    end

    logic unused_proto_err;
    assign unused_proto_err = proto_err;

    // ------------------------------------------------------------------
    // Registered read-data return
    // ------------------------------------------------------------------
    always_ff @(posedge clk_ir) begin
        if (!rst_sync_l) begin
            vga_rd_valid <= 1'b0;
            gpu_rd_valid <= 1'b0;
            vga_rdata    <= '0;
            gpu_rdata    <= '0;
        end else begin
            vga_rd_valid <= pop && !head_tag;
            gpu_rd_valid <= pop && head_tag;
            if (pop && !head_tag) vga_rdata <= sram_rdata;
            if (pop && head_tag)  gpu_rdata <= sram_rdata;
        end
    end

endmodule

// File: tb/tb_syn_sram_acc_arb.sv
// ============================================================================
// tb_syn_sram_acc_arb
// ----------------------------------------------------------------------------
// Directed self-checking bench for syn_sram_acc_arb. Inputs are driven on the
// falling edge. Outputs are sampled 1 ns later, which is well away from the
// rising edge.
// ============================================================================
module tb_syn_sram_acc_arb;

    localparam int AW = 18;
    localparam int DW = 16;
    localparam int MB = 16;
    localparam int OM = 4;
    localparam int SL = 8;

    logic          clk_ir = 1'b0;
    logic          rst_sync_l;
    logic          vga_req;
    logic [AW-1:0] vga_addr;
    logic          vga_ack;
    logic          vga_rd_valid;
    logic [DW-1:0] vga_rdata;
    logic          gpu_req;
    logic          gpu_wr;
    logic [AW-1:0] gpu_addr;
    logic [DW-1:0] gpu_wdata;
    logic          gpu_ack;
    logic          gpu_rd_valid;
    logic [DW-1:0] gpu_rdata;
    logic          sram_req;
    logic          sram_wr;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic          sram_ready;
    logic          sram_rd_valid;
    logic [DW-1:0] sram_rdata;

    always #5 clk_ir = ~clk_ir;

    syn_sram_acc_arb #(
        .P_ADDR_W    (AW),
        .P_DATA_W    (DW),
        .P_MAX_BURST (MB),
        .P_OUTST_MAX (OM),
        .P_STARVE_LIM(SL)
    ) dut (
        .clk_ir       (clk_ir),
        .rst_sync_l   (rst_sync_l),
        .vga_req      (vga_req),
        .vga_addr     (vga_addr),
        .vga_ack      (vga_ack),
        .vga_rd_valid (vga_rd_valid),
        .vga_rdata    (vga_rdata),
        .gpu_req      (gpu_req),
        .gpu_wr       (gpu_wr),
        .gpu_addr     (gpu_addr),
        .gpu_wdata    (gpu_wdata),
        .gpu_ack      (gpu_ack),
        .gpu_rd_valid (gpu_rd_valid),
        .gpu_rdata    (gpu_rdata),
        .sram_req     (sram_req),
        .sram_wr      (sram_wr),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_ready   (sram_ready),
        .sram_rd_valid(sram_rd_valid),
        .sram_rdata   (sram_rdata)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_sram_req"},     32'(sram_req),     32'd0);
        check({pfx, "_sram_wr"},      32'(sram_wr),      32'd0);
        check({pfx, "_sram_addr"},    32'(sram_addr),    32'd0);
        check({pfx, "_sram_wdata"},   32'(sram_wdata),   32'd0);
        check({pfx, "_vga_ack"},      32'(vga_ack),      32'd0);
        check({pfx, "_gpu_ack"},      32'(gpu_ack),      32'd0);
        check({pfx, "_vga_rd_valid"}, 32'(vga_rd_valid), 32'd0);
        check({pfx, "_gpu_rd_valid"}, 32'(gpu_rd_valid), 32'd0);
        check({pfx, "_vga_rdata"},    32'(vga_rdata),    32'd0);
        check({pfx, "_gpu_rdata"},    32'(gpu_rdata),    32'd0);
    endtask

    // Raise the requests until nv VGA and ng GPU transfers are acked, then
    // drop them. The loop is bounded, and a short count shows up as a failure.
    task automatic run_reqs(input int nv, input int ng, input logic gw, input string tag);
        int va = 0;
        int ga = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk_ir);
            vga_req = (va < nv);
            gpu_req = (ga < ng);
            gpu_wr  = gw;
            if (!vga_req && !gpu_req) break;
            #1;
            if (vga_ack) va++;
            if (gpu_ack) ga++;
        end
        vga_req = 1'b0;
        gpu_req = 1'b0;
        check({tag, "_vga_acks"}, 32'(va), 32'(nv));
        check({tag, "_gpu_acks"}, 32'(ga), 32'(ng));
    endtask

    // One return pulse, then a check of the routed valid and data one cycle
    // later, followed by an idle gap.
    task automatic ret_and_check(input logic [DW-1:0] data, input logic to_gpu, input string tag);
        @(negedge clk_ir);
        sram_rd_valid = 1'b1;
        sram_rdata    = data;
        #1;
        @(negedge clk_ir);
        sram_rd_valid = 1'b0;
        #1;
        check({tag, "_vga_valid"}, 32'(vga_rd_valid), 32'(!to_gpu));
        check({tag, "_gpu_valid"}, 32'(gpu_rd_valid), 32'(to_gpu));
        check({tag, "_rdata"}, 32'(to_gpu ? gpu_rdata : vga_rdata), 32'(data));
        @(negedge clk_ir);
    endtask

    int            acks;
    int            outst;
    int            first_gpu;
    logic          prev_ret;
    logic [DW-1:0] prev_data;
    logic [DW-1:0] ret_data;
    logic          exp_ack;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_sync_l    = 1'b0;
        vga_req       = 1'b0;
        vga_addr      = '0;
        gpu_req       = 1'b0;
        gpu_wr        = 1'b0;
        gpu_addr      = '0;
        gpu_wdata     = '0;
        sram_ready    = 1'b1;
        sram_rd_valid = 1'b0;
        sram_rdata    = '0;

        // Reset state
        repeat (3) @(negedge clk_ir);
        #1;
        check_all_zero("reset");
        @(negedge clk_ir);
        rst_sync_l = 1'b1;

        // 1: 40 VGA reads. Bursts of 16 with an IDLE gap; every return goes to VGA.
        acks = 0; outst = 0; prev_ret = 1'b0; prev_data = '0;
        for (int k = 0; k < 46; k++) begin
            @(negedge clk_ir);
            vga_req       = (acks < 40);
            vga_addr      = AW'(18'h20000 + k);
            sram_rd_valid = (outst > 0);
            ret_data      = DW'(16'hA000 + k);
            sram_rdata    = ret_data;
            #1;
            exp_ack = vga_req && (k != 0) && (k != 17) && (k != 34);
            check("t1_vga_ack", 32'(vga_ack), 32'(exp_ack));
            check("t1_gpu_ack", 32'(gpu_ack), 32'd0);
            if (exp_ack) check("t1_sram_addr", 32'(sram_addr), 32'(vga_addr));
            check("t1_vga_rd_valid", 32'(vga_rd_valid), 32'(prev_ret));
            check("t1_gpu_rd_valid", 32'(gpu_rd_valid), 32'd0);
            if (prev_ret) check("t1_vga_rdata", 32'(vga_rdata), 32'(prev_data));
            prev_ret  = sram_rd_valid;
            prev_data = ret_data;
            if (sram_rd_valid) outst--;
            if (vga_ack) begin
                acks++;
                outst++;
            end
        end
        sram_rd_valid = 1'b0;
        check("t1_total_acks", 32'(acks), 32'd40);
        check("t1_outstanding", 32'(outst), 32'd0);

        // 2: a single GPU write takes no tag
        @(negedge clk_ir);
        gpu_req = 1'b1; gpu_wr = 1'b1; gpu_addr = 18'h00100; gpu_wdata = 16'hBEEF;
        #1;
        check("t2_idle_sram_req", 32'(sram_req), 32'd0);
        @(negedge clk_ir);
        #1;
        check("t2_sram_req",   32'(sram_req),   32'd1);
        check("t2_sram_wr",    32'(sram_wr),    32'd1);
        check("t2_sram_addr",  32'(sram_addr),  32'h00100);
        check("t2_sram_wdata", 32'(sram_wdata), 32'hBEEF);
        check("t2_gpu_ack",    32'(gpu_ack),    32'd1);
        check("t2_vga_ack",    32'(vga_ack),    32'd0);
        @(negedge clk_ir);
        gpu_req = 1'b0; gpu_wr = 1'b0;
        sram_rd_valid = 1'b1; sram_rdata = 16'hDEAD;
        #1;
        @(negedge clk_ir);
        sram_rd_valid = 1'b0;
        #1;
        check("t2_no_gpu_rd_valid", 32'(gpu_rd_valid), 32'd0);
        check("t2_no_vga_rd_valid", 32'(vga_rd_valid), 32'd0);

        // 3: both request at once; VGA wins 3 reads, then the GPU read. Returns V,V,V,G.
        run_reqs(3, 1, 1'b0, "t3");
        ret_and_check(16'h1111, 1'b0, "t3_ret0");
        ret_and_check(16'h2222, 1'b0, "t3_ret1");
        ret_and_check(16'h3333, 1'b0, "t3_ret2");
        ret_and_check(16'h4444, 1'b1, "t3_ret3");

        // 4: a 5th read stalls while 4 are outstanding and goes on the first return
        run_reqs(4, 0, 1'b0, "t4");
        @(negedge clk_ir);
        vga_req = 1'b1;
        #1;
        check("t4_idle_sram_req", 32'(sram_req), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_ir);
            #1;
            check("t4_stall_sram_req", 32'(sram_req), 32'd0);
            check("t4_stall_vga_ack",  32'(vga_ack),  32'd0);
        end
        @(negedge clk_ir);
        sram_rd_valid = 1'b1; sram_rdata = 16'h5555;
        #1;
        check("t4_unstall_sram_req", 32'(sram_req), 32'd1);
        check("t4_unstall_vga_ack",  32'(vga_ack),  32'd1);
        @(negedge clk_ir);
        vga_req = 1'b0; sram_rd_valid = 1'b0;
        #1;
        check("t4_first_ret_valid", 32'(vga_rd_valid), 32'd1);
        check("t4_first_ret_data",  32'(vga_rdata),    32'h5555);
        for (int i = 0; i < 4; i++) ret_and_check(DW'(16'h6000 + i), 1'b0, "t4_drain");

        // 5: both request without a break; the GPU is served only with the guard
        outst = 0; first_gpu = -1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk_ir);
            vga_req = 1'b1; gpu_req = 1'b1; gpu_wr = 1'b0;
            sram_rd_valid = (outst > 0); sram_rdata = DW'(16'h7000 + c);
            #1;
            if (gpu_ack && first_gpu < 0) first_gpu = c;
            if (sram_rd_valid) outst--;
            if (vga_ack || gpu_ack) outst++;
        end
        @(negedge clk_ir);
        vga_req = 1'b0; gpu_req = 1'b0;
        sram_rd_valid = (outst > 0);
        #1;
        if (sram_rd_valid) outst--;
        @(negedge clk_ir);
        sram_rd_valid = 1'b0;
`ifdef SYN_SRAM_ARB_STARVE_GUARD_EN
        check("t5_gpu_ack_in_time", 32'(first_gpu >= 0 && first_gpu <= SL + MB + 2), 32'd1);
`else
        check("t5_gpu_starved", 32'(first_gpu >= 0), 32'd0);
`endif
        check("t5_outstanding", 32'(outst), 32'd0);

        // 6: reset mid-burst with 2 reads outstanding
        @(negedge clk_ir);
        vga_req = 1'b1;
        #1;
        @(negedge clk_ir);
        #1;
        check("t6_ack1", 32'(vga_ack), 32'd1);
        @(negedge clk_ir);
        #1;
        check("t6_ack2", 32'(vga_ack), 32'd1);
        rst_sync_l = 1'b0;
        @(negedge clk_ir);
        #1;
        check_all_zero("t6_rst");
        @(negedge clk_ir);
        rst_sync_l = 1'b1; vga_req = 1'b0;
        sram_rd_valid = 1'b1; sram_rdata = 16'h7777;
        #1;
        @(negedge clk_ir);
        #1;
        check("t6_drop_vga_0", 32'(vga_rd_valid), 32'd0);
        check("t6_drop_gpu_0", 32'(gpu_rd_valid), 32'd0);
        @(negedge clk_ir);
        sram_rd_valid = 1'b0;
        #1;
        check("t6_drop_vga_1", 32'(vga_rd_valid), 32'd0);
        check("t6_drop_gpu_1", 32'(gpu_rd_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
